// File: rtl/inst_fetch_buffer.sv
// Instruction prefetch queue: issues one instruction-memory read at a time from
// the current PC and buffers returned words with their addresses for decode.
module inst_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_pc,
    output logic             o_pc_enable,
    input  logic             i_flush,
    output logic             o_mem_req,
    output logic [31:0]      o_mem_addr,
    input  logic             i_mem_ack,
    input  logic [31:0]      i_mem_rdata,
    output logic             o_dec_valid,
    input  logic             i_dec_ready,
    output logic [31:0]      o_dec_inst,
    output logic [31:0]      o_dec_pc,
    output logic [CNT_W-1:0] o_count,
    output logic [1:0]       o_state
);

    // Memory handshake: mem_req rises with mem_addr and both stay stable until
    // the cycle mem_ack=1 is sampled; acks while mem_req=0 are ignored.
    // Decode handshake: the head entry transfers on any edge with dec_valid & dec_ready.

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_mem_req;
    logic [31:0]        r_mem_addr;
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_inst_mem [DEPTH];
    logic [31:0]        r_pc_mem   [DEPTH];

    logic               w_room;
    logic               w_push;
    logic               w_pop;
    logic               w_dec_valid;
    logic               w_pc_enable;

    assign w_room      = (r_count < DEPTH_C);
    assign w_dec_valid = (r_count != '0);
    assign w_pop       = w_dec_valid & i_dec_ready;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!i_flush && w_room) w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (i_mem_ack)    w_next_state = S_IDLE;
                else if (i_flush) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (i_mem_ack) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // The flush term lets inst_fetch load the redirect target in the flush cycle.
    always_comb begin
        w_push      = 1'b0;
        w_pc_enable = 1'b0;
        if (r_state == S_WAIT && i_mem_ack && !i_flush) w_push = 1'b1;
        w_pc_enable = i_reset & (w_push | i_flush);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
        end else begin
            r_mem_req <= (w_next_state != S_IDLE);
            if (r_state == S_IDLE && w_next_state == S_WAIT) r_mem_addr <= i_pc;
        end
    end

    // Flush beats any same-cycle push or pop.
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && i_reset) begin
            r_inst_mem[r_wptr] <= i_mem_rdata;
            r_pc_mem[r_wptr]   <= r_mem_addr;
        end
    end

    assign o_pc_enable = w_pc_enable;
    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_dec_valid = w_dec_valid;
    assign o_dec_inst  = w_dec_valid ? r_inst_mem[r_rptr] : 32'h0;
    assign o_dec_pc    = w_dec_valid ? r_pc_mem[r_rptr]   : 32'h0;
    assign o_count     = r_count;
    assign o_state     = r_state;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: a small PC/memory model drives the block and
// a queue of expected {pc, inst} entries is compared against the decode port every cycle.
module tb_inst_fetch_buffer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pc;
    logic        o_pc_enable;
    logic        i_flush;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_dec_valid;
    logic        i_dec_ready;
    logic [31:0] o_dec_inst;
    logic [31:0] o_dec_pc;
    logic [2:0]  o_count;
    logic [1:0]  o_state;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    inst_fetch_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_pc        (i_pc),
        .o_pc_enable (o_pc_enable),
        .i_flush     (i_flush),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_dec_valid (o_dec_valid),
        .i_dec_ready (i_dec_ready),
        .o_dec_inst  (o_dec_inst),
        .o_dec_pc    (o_dec_pc),
        .o_count     (o_count),
        .o_state     (o_state)
    );

    always #5 i_clk = ~i_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pen_cnt = 0;
    int          pop_cnt = 0;
    int          pen_before;
    logic        auto_mem = 1'b0;
    logic [31:0] redirect = 32'h0;
    logic [63:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: model inst_fetch PC update, scoreboard push/pop/flush, memory responder.
    task automatic tick();
        logic        pen, fl, rs, pop, push, req_before;
        logic [31:0] pc_old, rdata;
        logic [63:0] head;
        #1;
        pen        = o_pc_enable;
        fl         = i_flush;
        rs         = i_reset;
        pc_old     = i_pc;
        rdata      = i_mem_rdata;
        req_before = o_mem_req;
        pop        = rs && !fl && (exp_q.size() != 0) && i_dec_ready;
        push       = pen && !fl;
        @(posedge i_clk);
        #1;
        if (!rs || fl) begin
            exp_q.delete();
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                pop_cnt++;
            end
            if (push) exp_q.push_back({pc_old, rdata});
        end
        if (pen) begin
            pen_cnt++;
            i_pc = fl ? redirect : pc_old + 32'd4;
        end
        if (o_mem_req && !req_before) check("issue_addr", o_mem_addr, i_pc);
        if (auto_mem) begin
            i_mem_ack   = o_mem_req;
            i_mem_rdata = mem_word(o_mem_addr);
        end
        head = (exp_q.size() != 0) ? exp_q[0] : 64'h0;
        check("count", 32'(o_count), 32'(exp_q.size()));
        check("dec_valid", 32'(o_dec_valid), 32'(exp_q.size() != 0));
        check("dec_pc", o_dec_pc, head[63:32]);
        check("dec_inst", o_dec_inst, head[31:0]);
    endtask

    initial begin
        i_reset     = 1'b0;
        i_flush     = 1'b1;
        i_pc        = 32'h0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
        i_dec_ready = 1'b0;

        // Reset: outputs cleared, pc_enable gated even with flush high
        tick();
        tick();
        #1;
        check("rst_pc_enable", 32'(o_pc_enable), 32'd0);
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'h0);
        check("rst_state", 32'(o_state), 32'(ST_IDLE));

        // Fill: zero-wait memory, decode stalled
        i_reset  = 1'b1;
        i_flush  = 1'b0;
        auto_mem = 1'b1;
        pen_cnt  = 0;
        for (int i = 0; i < 20; i++) tick();
        check("fill_count", 32'(o_count), 32'd4);
        check("fill_mem_req", 32'(o_mem_req), 32'd0);
        check("fill_pen_pulses", 32'(pen_cnt), 32'd4);
        check("fill_state", 32'(o_state), 32'(ST_IDLE));

        // Drain while fetching
        i_dec_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        check("drain_pops", 32'(pop_cnt >= 8), 32'd1);

        // Flush in WAIT without ack
        i_dec_ready = 1'b0;
        auto_mem    = 1'b0;
        i_mem_ack   = 1'b0;
        for (int i = 0; i < 10 && !o_mem_req; i++) tick();
        check("reach_wait", 32'(o_state), 32'(ST_WAIT));
        tick();
        i_flush  = 1'b1;
        redirect = 32'h100;
        #1;
        check("flush_pc_enable", 32'(o_pc_enable), 32'd1);
        tick();
        check("flush_state", 32'(o_state), 32'(ST_DRAIN));
        check("flush_mem_req", 32'(o_mem_req), 32'd1);
        i_flush     = 1'b0;
        i_dec_ready = 1'b1;
        tick();
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hDEADBEEF;
        #1;
        check("drain_pc_enable", 32'(o_pc_enable), 32'd0);
        tick();
        check("drain_done_state", 32'(o_state), 32'(ST_IDLE));
        check("drain_no_push", 32'(o_count), 32'd0);
        i_mem_ack   = 1'b0;
        i_dec_ready = 1'b0;
        tick();
        check("redirect_addr", o_mem_addr, 32'h100);
        check("redirect_req", 32'(o_mem_req), 32'd1);

        // Flush coincident with ack and pop at count=2
        auto_mem = 1'b1;
        for (int i = 0; i < 20 && !(o_count == 3'd2 && o_mem_req); i++) tick();
        check("reach_cnt2", 32'(o_count == 3'd2 && o_mem_req), 32'd1);
        i_flush     = 1'b1;
        i_dec_ready = 1'b1;
        redirect    = 32'h200;
        #1;
        check("coinc_pc_enable", 32'(o_pc_enable), 32'd1);
        pen_before = pen_cnt;
        tick();
        check("coinc_count", 32'(o_count), 32'd0);
        check("coinc_state", 32'(o_state), 32'(ST_IDLE));
        check("coinc_mem_req", 32'(o_mem_req), 32'd0);
        check("coinc_single_pen", 32'(pen_cnt), 32'(pen_before + 1));
        i_flush     = 1'b0;
        i_dec_ready = 1'b0;
        auto_mem    = 1'b0;
        i_mem_ack   = 1'b0;
        tick();
        check("coinc_next_addr", o_mem_addr, 32'h200);

        // Mid-request reset, then a late ack
        i_reset = 1'b0;
        tick();
        check("mrst_mem_req", 32'(o_mem_req), 32'd0);
        check("mrst_state", 32'(o_state), 32'(ST_IDLE));
        i_reset     = 1'b1;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h12345678;
        #1;
        check("late_ack_pen", 32'(o_pc_enable), 32'd0);
        tick();
        i_mem_ack = 1'b0;
        check("mrst_count", 32'(o_count), 32'd0);
        check("mrst_reissue_req", 32'(o_mem_req), 32'd1);
        check("mrst_reissue_addr", o_mem_addr, 32'h200);

        // Wrap-around with decode ready toggling
        auto_mem = 1'b1;
        pop_cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            i_dec_ready = i[0];
            tick();
        end
        check("wrap_pops", 32'(pop_cnt >= 10), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
